// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM state codes, the 4-bit
// opcode map and the two ALU function codes the controller issues itself.
package ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Opcodes 0x0..OPC_RTYPE_MAX are R-type; the value doubles as the ALU function.
  localparam logic [3:0] OPC_RTYPE_MAX = 4'h7;
  localparam logic [3:0] OPC_ADDI      = 4'h8;
  localparam logic [3:0] OPC_LW        = 4'h9;
  localparam logic [3:0] OPC_SW        = 4'hA;
  localparam logic [3:0] OPC_BEQ       = 4'hB;
  localparam logic [3:0] OPC_JMP       = 4'hC;
  localparam logic [3:0] OPC_NOP       = 4'hD;
  localparam logic [3:0] OPC_RSV       = 4'hE;
  localparam logic [3:0] OPC_HALT      = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

endpackage

// File: rtl/ctrl_opc_class.sv
// Combinational opcode classifier: turns the registered IR opcode into one-hot
// instruction-class flags for the sequencer.
module ctrl_opc_class
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode_i,
  output logic             is_rtype_o,
  output logic             is_addi_o,
  output logic             is_lw_o,
  output logic             is_sw_o,
  output logic             is_beq_o,
  output logic             is_jmp_o,
  output logic             is_halt_o,
  output logic             is_nop_o
);

  assign is_rtype_o = (opcode_i <= OPC_W'(OPC_RTYPE_MAX));
  assign is_addi_o  = (opcode_i == OPC_W'(OPC_ADDI));
  assign is_lw_o    = (opcode_i == OPC_W'(OPC_LW));
  assign is_sw_o    = (opcode_i == OPC_W'(OPC_SW));
  assign is_beq_o   = (opcode_i == OPC_W'(OPC_BEQ));
  assign is_jmp_o   = (opcode_i == OPC_W'(OPC_JMP));
  assign is_halt_o  = (opcode_i == OPC_W'(OPC_HALT));
  // The reserved opcode retires exactly like NOP.
  assign is_nop_o   = (opcode_i == OPC_W'(OPC_NOP)) || (opcode_i == OPC_W'(OPC_RSV));

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core; outputs are Mealy on
// ready/zero. Optional perf counters are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               alu_zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               reg_we,
  output logic               alu_src_imm,
  output logic               wb_sel_mem,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               halted
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_instrs
`endif
);

  state_e state_q, state_d;

  logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_jmp, is_halt, is_nop;

  ctrl_opc_class #(
    .OPC_W (OPC_W)
  ) u_opc_class (
    .opcode_i   (opcode),
    .is_rtype_o (is_rtype),
    .is_addi_o  (is_addi),
    .is_lw_o    (is_lw),
    .is_sw_o    (is_sw),
    .is_beq_o   (is_beq),
    .is_jmp_o   (is_jmp),
    .is_halt_o  (is_halt),
    .is_nop_o   (is_nop)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel_mem  = 1'b0;
    alu_op      = ALUOP_W'(ALU_ADD);
    halted      = 1'b0;

    // Reset silences every output in the same cycle; the register handles the restart.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_DECODE;
          end
        end

        S_DECODE: begin
          if (is_jmp) begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end else if (is_halt) begin
            state_d = S_HALT;
          end else if (is_nop) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          alu_src_imm = is_addi || is_lw || is_sw;
          if (is_rtype) begin
            alu_op = ALUOP_W'(opcode);
          end else if (is_beq) begin
            alu_op = ALUOP_W'(ALU_SUB);
          end
          if (is_beq) begin
            pc_load = alu_zero;
            state_d = S_FETCH;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end

        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_sw;
          if (dmem_ready) begin
            state_d = is_lw ? S_WB : S_FETCH;
          end
        end

        S_WB: begin
          reg_we     = 1'b1;
          wb_sel_mem = is_lw;
          state_d    = S_FETCH;
        end

        S_HALT: begin
          halted = 1'b1;
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_instrs_q;

  // An instruction retires on each return to FETCH from a different state.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_instrs_q <= '0;
    end else begin
      if (state_q != S_HALT) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
        perf_instrs_q <= perf_instrs_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_instrs = perf_instrs_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; expected output vectors are
// hand-derived per cycle. Perf-counter checks compile in with CTRL_PERF_CNT_EN.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       alu_zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       ir_load, pc_inc, pc_load, imem_req, dmem_req, dmem_we;
  logic       reg_we, alu_src_imm, wb_sel_mem, halted;
  logic [3:0] alu_op;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_instrs;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Output vector bit order:
  // {ir_load, pc_inc, pc_load, imem_req, dmem_req, dmem_we, reg_we, alu_src_imm, wb_sel_mem, halted}
  localparam logic [9:0] O_IDLE       = 10'b00_0000_0000;
  localparam logic [9:0] O_FETCH_HIT  = 10'b11_0100_0000;
  localparam logic [9:0] O_FETCH_WAIT = 10'b00_0100_0000;
  localparam logic [9:0] O_PC_LOAD    = 10'b00_1000_0000;
  localparam logic [9:0] O_IMM        = 10'b00_0000_0100;
  localparam logic [9:0] O_MEM_RD     = 10'b00_0010_0000;
  localparam logic [9:0] O_MEM_WR     = 10'b00_0011_0000;
  localparam logic [9:0] O_WB_ALU     = 10'b00_0000_1000;
  localparam logic [9:0] O_WB_MEM     = 10'b00_0000_1010;
  localparam logic [9:0] O_HALT       = 10'b00_0000_0001;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .OPC_W   (4),
    .ALUOP_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .alu_zero    (alu_zero),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .reg_we      (reg_we),
    .alu_src_imm (alu_src_imm),
    .wb_sel_mem  (wb_sel_mem),
    .alu_op      (alu_op),
    .halted      (halted)
`ifdef CTRL_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_instrs (perf_instrs)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {ir_load, pc_inc, pc_load, imem_req, dmem_req, dmem_we,
            reg_we, alu_src_imm, wb_sel_mem, halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH: checks the ir_load/pc_inc pair, then the DECODE cycle for op.
  task automatic fetch_decode(input string tag, input logic [3:0] op, input logic [9:0] exp_dec);
    imem_ready = 1'b1;
    #1;
    check({tag, "_fetch"}, 32'(outs()), 32'(O_FETCH_HIT));
    tick();
    opcode = op;
    #1;
    check({tag, "_decode"}, 32'(outs()), 32'(exp_dec));
  endtask

  // The two memory requests must never overlap.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("req_excl", 32'(imem_req & dmem_req), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    opcode     = 4'hF;
    alu_zero   = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    repeat (2) tick();
    check("rst_outs",  32'(outs()), 32'(O_IDLE));
    check("rst_aluop", 32'(alu_op), 32'd0);
    reset      = 1'b0;
    dmem_ready = 1'b0;

    // R-type 0x3: ir_load@1, EXEC@3, reg_we@4, FETCH again @5.
    fetch_decode("r3", 4'h3, O_IDLE);
    tick();
    check("r3_exec",  32'(outs()), 32'(O_IDLE));
    check("r3_aluop", 32'(alu_op), 32'h3);
    tick();
    check("r3_wb", 32'(outs()), 32'(O_WB_ALU));
    tick();

    // LW with three dmem wait cycles; imem_ready stays high and must be ignored.
    fetch_decode("lw", 4'h9, O_IDLE);
    tick();
    check("lw_exec",  32'(outs()), 32'(O_IMM));
    check("lw_aluop", 32'(alu_op), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lw_mem_wait", 32'(outs()), 32'(O_MEM_RD));
    end
    tick();
    dmem_ready = 1'b1;
    #1;
    check("lw_mem_done", 32'(outs()), 32'(O_MEM_RD));
    tick();
    check("lw_wb", 32'(outs()), 32'(O_WB_MEM));
    tick();

    // ADDI with dmem_ready high during FETCH (ignored there).
    fetch_decode("addi", 4'h8, O_IDLE);
    tick();
    check("addi_exec",  32'(outs()), 32'(O_IMM));
    check("addi_aluop", 32'(alu_op), 32'h0);
    tick();
    check("addi_wb", 32'(outs()), 32'(O_WB_ALU));
    tick();

    // BEQ taken, then BEQ not taken.
    fetch_decode("beq1", 4'hB, O_IDLE);
    tick();
    alu_zero = 1'b1;
    #1;
    check("beq1_exec",  32'(outs()), 32'(O_PC_LOAD));
    check("beq1_aluop", 32'(alu_op), 32'h1);
    tick();
    fetch_decode("beq0", 4'hB, O_IDLE);
    tick();
    alu_zero = 1'b0;
    #1;
    check("beq0_exec",  32'(outs()), 32'(O_IDLE));
    check("beq0_aluop", 32'(alu_op), 32'h1);
    tick();

    // Instruction fetch stalled for five cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_fetch", 32'(outs()), 32'(O_FETCH_WAIT));
      tick();
    end
    fetch_decode("nop", 4'hD, O_IDLE);
    tick();
    fetch_decode("jmp", 4'hC, O_PC_LOAD);
    tick();
    fetch_decode("rsv", 4'hE, O_IDLE);
    tick();

    // SW with zero-wait memory.
    fetch_decode("sw", 4'hA, O_IDLE);
    tick();
    check("sw_exec", 32'(outs()), 32'(O_IMM));
    tick();
    check("sw_mem", 32'(outs()), 32'(O_MEM_WR));
    tick();

    // SW interrupted by reset while waiting on dmem.
    dmem_ready = 1'b0;
    fetch_decode("swr", 4'hA, O_IDLE);
    tick();
    tick();
    check("swr_mem0", 32'(outs()), 32'(O_MEM_WR));
    tick();
    check("swr_mem1", 32'(outs()), 32'(O_MEM_WR));
    reset = 1'b1;
    #1;
    check("swr_rst", 32'(outs()), 32'(O_IDLE));
    tick();
    reset      = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b1;
    #1;
    check("swr_restart", 32'(outs()), 32'(O_FETCH_WAIT));

    // HALT holds for 20 cycles regardless of inputs, then only reset exits.
    fetch_decode("halt", 4'hF, O_IDLE);
    tick();
    for (int i = 0; i < 20; i++) begin
      alu_zero = i[0];
      #1;
      check("halt_hold", 32'(outs()), 32'(O_HALT));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("halt_exit", 32'(outs()), 32'(O_FETCH_HIT));

`ifdef CTRL_PERF_CNT_EN
    // Three NOPs then HALT at zero wait: 8 active cycles, 3 retired instructions.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("perf_rst_cycles", perf_cycles, 32'd0);
    check("perf_rst_instrs", perf_instrs, 32'd0);
    for (int i = 0; i < 3; i++) begin
      fetch_decode("pnop", 4'hD, O_IDLE);
      tick();
    end
    fetch_decode("phalt", 4'hF, O_IDLE);
    tick();
    check("perf_halt_outs", 32'(outs()), 32'(O_HALT));
    check("perf_cycles",    perf_cycles, 32'd8);
    check("perf_instrs",    perf_instrs, 32'd3);
    repeat (5) tick();
    check("perf_cycles_frozen", perf_cycles, 32'd8);
    check("perf_instrs_frozen", perf_instrs, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
